// File: rtl/uart_tx_serializer.sv
// UART transmitter: serializes bytes from a valid/ready stream onto tx_o.
// Frame: start(0), 8 data bits LSB first, optional even parity, 1 or 2 stop bits.
module uart_tx_serializer #(
  parameter int unsigned DIV_WIDTH         = 16,
  parameter int unsigned PARITY_EN_DEFAULT = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_en_i,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  input  logic                 cfg_parity_en_i,
  input  logic                 cfg_stop_bits_i,
  input  logic [7:0]           data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 done_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t               state;
  logic [DIV_WIDTH-1:0] baud_cnt;
  logic [DIV_WIDTH-1:0] div_q;
  logic [2:0]           bit_cnt;
  logic [7:0]           shreg;
  logic                 par_en_q;
  logic                 par_bit_q;
  logic                 stop2_q;
  logic                 stop_cnt;
  logic                 tx_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 bit_end_c;

  // The parity-enable port is authoritative; the default is integration documentation only.
  logic unused_parity_default;
  assign unused_parity_default = (PARITY_EN_DEFAULT != 0);

  // Last cycle of the current bit period (equality compare, so div=all-ones cannot overflow).
  assign bit_end_c = (baud_cnt == div_q);

  assign ready_o = ready_q;
  assign tx_o    = tx_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

  // Frame FSM with baud counter, shift register and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      div_q     <= '0;
      bit_cnt   <= 3'd0;
      shreg     <= 8'd0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      stop_cnt  <= 1'b0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (state != IDLE) begin
        baud_cnt <= bit_end_c ? '0 : baud_cnt + DIV_WIDTH'(1);
      end

      case (state)
        IDLE: begin
          if (valid_i && ready_q) begin
            div_q     <= cfg_div_i;
            par_en_q  <= cfg_parity_en_i;
            stop2_q   <= cfg_stop_bits_i;
            shreg     <= data_i;
            par_bit_q <= ^data_i;
            baud_cnt  <= '0;
            bit_cnt   <= 3'd0;
            stop_cnt  <= 1'b0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            ready_q   <= 1'b0;
            state     <= START;
          end else begin
            ready_q <= cfg_en_i;
          end
        end

        START: begin
          if (bit_end_c) begin
            tx_q    <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            bit_cnt <= 3'd0;
            state   <= DATA;
          end
        end

        DATA: begin
          if (bit_end_c) begin
            if (bit_cnt == 3'd7) begin
              if (par_en_q) begin
                tx_q  <= par_bit_q;
                state <= PARITY;
              end else begin
                tx_q     <= 1'b1;
                stop_cnt <= 1'b0;
                state    <= STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx_q    <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end
        end

        PARITY: begin
          if (bit_end_c) begin
            tx_q     <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= STOP;
          end
        end

        STOP: begin
          if (bit_end_c) begin
            if (stop2_q && !stop_cnt) begin
              stop_cnt <= 1'b1;
            end else begin
              state   <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              ready_q <= cfg_en_i;
            end
          end
        end

        default: begin
          state <= IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: table vectors, random frames, corner sequences.
module tb_uart_tx_serializer;

  localparam int unsigned DW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          cfg_en_i;
  logic [DW-1:0] cfg_div_i;
  logic          cfg_parity_en_i;
  logic          cfg_stop_bits_i;
  logic [7:0]    data_i;
  logic          valid_i;
  logic          ready_o;
  logic          tx_o;
  logic          busy_o;
  logic          done_o;

  int checks   = 0;
  int failures = 0;

  logic exp_bits[$];

  typedef struct {
    logic [7:0] d;
    int         div;
    bit         par;
    bit         s2;
    int         exp_len;
  } vec_t;

  vec_t vecs[6];

  uart_tx_serializer #(.DIV_WIDTH(DW), .PARITY_EN_DEFAULT(1)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .cfg_en_i        (cfg_en_i),
    .cfg_div_i       (cfg_div_i),
    .cfg_parity_en_i (cfg_parity_en_i),
    .cfg_stop_bits_i (cfg_stop_bits_i),
    .data_i          (data_i),
    .valid_i         (valid_i),
    .ready_o         (ready_o),
    .tx_o            (tx_o),
    .busy_o          (busy_o),
    .done_o          (done_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Reference frame as a list of line levels, one entry per bit period.
  task automatic fill_model(input logic [7:0] d, input bit par, input bit s2);
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
    if (par) exp_bits.push_back(^d);
    exp_bits.push_back(1'b1);
    if (s2) exp_bits.push_back(1'b1);
  endtask

  // Present a byte, wait for acceptance, then check every frame cycle and the completion pulse.
  task automatic run_frame(input string tag, input logic [7:0] d, input int div, input bit par,
                           input bit s2, input int exp_len, input int mid);
    int   n;
    int   bad;
    int   first_bad;
    logic expb;
    fill_model(d, par, s2);
    cfg_div_i       = DW'(div);
    cfg_parity_en_i = par;
    cfg_stop_bits_i = s2;
    data_i          = d;
    valid_i         = 1'b1;
    n = 0;
    while (ready_o !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (ready_o !== 1'b1) begin
      chk({tag, "_ready_timeout"}, 32'(ready_o), 32'd1);
      valid_i = 1'b0;
      return;
    end
    step();
    valid_i         = 1'b0;
    data_i          = ~d;
    cfg_div_i       = DW'($urandom);
    cfg_parity_en_i = ~par;
    cfg_stop_bits_i = ~s2;
    bad       = 0;
    first_bad = -1;
    for (int c = 0; c < exp_len; c++) begin
      expb = (c / (div + 1) < exp_bits.size()) ? exp_bits[c / (div + 1)] : 1'b1;
      if (tx_o !== expb || busy_o !== 1'b1 || done_o !== 1'b0 || ready_o !== 1'b0) begin
        if (bad == 0) first_bad = c;
        bad++;
      end
      if (c == mid) begin
        cfg_en_i  = 1'b0;
        cfg_div_i = DW'(7);
      end
      step();
    end
    if (bad != 0) $display("  %s first bad cycle %0d", tag, first_bad);
    chk({tag, "_wave_errs"}, 32'(bad), 32'd0);
    chk({tag, "_end_done_busy_tx"}, 32'({done_o, busy_o, tx_o}), 32'b101);
    chk({tag, "_end_ready"}, 32'(ready_o), 32'(cfg_en_i));
    step();
    chk({tag, "_done_one_cycle"}, 32'(done_o), 32'd0);
  endtask

  initial begin
    int   start2;
    int   done1;
    int   c;
    int   bad;
    int   div;
    bit   par;
    bit   s2;
    logic [7:0] d;
    string hello;

    vecs[0] = '{8'hA5, 3,  1'b1, 1'b0, 44};
    vecs[1] = '{8'h07, 0,  1'b1, 1'b1, 12};
    vecs[2] = '{8'h00, 0,  1'b0, 1'b0, 10};
    vecs[3] = '{8'hFF, 15, 1'b1, 1'b1, 192};
    vecs[4] = '{8'h80, 2,  1'b0, 1'b1, 33};
    vecs[5] = '{8'h3C, 1,  1'b1, 1'b0, 22};

    rst_i           = 1'b1;
    cfg_en_i        = 1'b1;
    cfg_div_i       = '0;
    cfg_parity_en_i = 1'b0;
    cfg_stop_bits_i = 1'b0;
    data_i          = 8'h00;
    valid_i         = 1'b0;
    repeat (3) step();
    chk("reset_tx_ready_busy_done", 32'({tx_o, ready_o, busy_o, done_o}), 32'b1000);
    rst_i = 1'b0;
    step();
    chk("ready_after_reset", 32'({tx_o, ready_o, busy_o}), 32'b110);

    // Reset and valid together: reset wins, nothing accepted.
    rst_i   = 1'b1;
    valid_i = 1'b1;
    step();
    chk("rst_valid_same_edge", 32'({tx_o, ready_o, busy_o, done_o}), 32'b1000);
    rst_i   = 1'b0;
    valid_i = 1'b0;
    step();
    chk("rst_valid_no_frame", 32'({tx_o, ready_o, busy_o}), 32'b110);

    for (int i = 0; i < 6; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].d, vecs[i].div, vecs[i].par, vecs[i].s2,
                vecs[i].exp_len, -1);
    end

    // Back-to-back frames with valid held: second start 21 cycles after the first.
    fill_model(8'h0A, 1'b0, 1'b0);
    cfg_div_i = DW'(1);
    cfg_parity_en_i = 1'b0;
    cfg_stop_bits_i = 1'b0;
    data_i  = 8'h55;
    valid_i = 1'b1;
    c = 0;
    while (ready_o !== 1'b1 && c < 50) begin
      step();
      c++;
    end
    step();
    data_i = 8'h0A;
    chk("b2b_first_start", 32'(tx_o), 32'd0);
    start2 = -1;
    done1  = -1;
    c = 0;
    while (start2 < 0 && c < 60) begin
      if (done_o === 1'b1 && done1 < 0) done1 = c;
      if (c >= 20 && tx_o === 1'b0) start2 = c;
      else begin
        step();
        c++;
      end
    end
    valid_i = 1'b0;
    chk("b2b_done_cycle", 32'(done1), 32'd20);
    chk("b2b_second_start", 32'(start2), 32'd21);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (tx_o !== exp_bits[k / 2] || busy_o !== 1'b1) bad++;
      step();
    end
    chk("b2b_second_wave_errs", 32'(bad), 32'd0);
    chk("b2b_second_done", 32'({done_o, busy_o, tx_o}), 32'b101);
    step();
    chk("b2b_no_third_frame", 32'({done_o, busy_o, tx_o}), 32'b001);

    // Reset during data bit 3 of 0xFF aborts the frame without a done pulse.
    cfg_div_i = DW'(1);
    cfg_parity_en_i = 1'b1;
    cfg_stop_bits_i = 1'b0;
    data_i  = 8'hFF;
    valid_i = 1'b1;
    c = 0;
    while (ready_o !== 1'b1 && c < 50) begin
      step();
      c++;
    end
    step();
    valid_i = 1'b0;
    repeat (8) step();
    chk("rst_mid_pre_busy", 32'(busy_o), 32'd1);
    rst_i   = 1'b1;
    valid_i = 1'b1;
    step();
    chk("rst_mid_outputs", 32'({tx_o, ready_o, busy_o, done_o}), 32'b1000);
    step();
    chk("rst_mid_hold", 32'({tx_o, ready_o, busy_o, done_o}), 32'b1000);
    rst_i   = 1'b0;
    valid_i = 1'b0;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (done_o !== 1'b0 || tx_o !== 1'b1 || busy_o !== 1'b0) bad++;
    end
    chk("rst_mid_no_done", 32'(bad), 32'd0);
    chk("rst_mid_ready_back", 32'(ready_o), 32'd1);
    run_frame("post_rst", 8'h5A, 2, 1'b1, 1'b0, 33, -1);

    // Random frames against the reference model.
    for (int i = 0; i < 20; i++) begin
      d   = 8'($urandom);
      div = int'($urandom_range(0, 5));
      par = 1'($urandom);
      s2  = 1'($urandom);
      run_frame($sformatf("rnd%0d", i), d, div, par, s2, (10 + int'(par) + int'(s2)) * (div + 1), -1);
    end

    // Text stream at a fixed baud.
    hello = "Hello\n";
    for (int i = 0; i < hello.len(); i++) begin
      run_frame($sformatf("hello%0d", i), hello[i], 3, 1'b1, 1'b0, 44, -1);
    end

    // Mid-frame cfg_div change and enable drop: frame finishes at old rate, then no accepts.
    run_frame("cfg_change", 8'hC3, 3, 1'b1, 1'b0, 44, 10);
    valid_i = 1'b1;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      if (ready_o !== 1'b0 || busy_o !== 1'b0 || tx_o !== 1'b1) bad++;
      step();
    end
    chk("cfg_disabled_no_accept", 32'(bad), 32'd0);
    valid_i  = 1'b0;
    cfg_en_i = 1'b1;
    step();
    step();
    chk("cfg_reenabled_ready", 32'(ready_o), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Synthesizable UART transmitter that serializes bytes from a valid/ready stream onto a single TX line.
- Sits directly upstream of the UART RX monitor/console dump in the uDMA UART VIP bench: its tx_o drives the monitor's rx line.
- Frame format: 1 start bit (0), 8 data bits LSB first, optional even parity bit, 1 or 2 stop bits (1).
- Parity polarity makes the XOR of the 8 data bits and the parity bit equal 0, which is what the downstream monitor checks.

Parameters:
- DIV_WIDTH, 16, width of the baud divider configuration.
- PARITY_EN_DEFAULT, 1, parity enable applied when cfg_parity_en_i is tied off by the integrator (documentation default only; the port is authoritative).

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  reset.
- cfg_en_i  input  1  transmitter enable; gates acceptance of new bytes.
- cfg_div_i  input  DIV_WIDTH  clock cycles per bit minus 1.
- cfg_parity_en_i  input  1  1 = insert even parity bit.
- cfg_stop_bits_i  input  1  0 = one stop bit, 1 = two stop bits.
- data_i  input  8  byte to transmit.
- valid_i  input  1  data_i valid.
- ready_o  output  1  block can accept data_i.
- tx_o  output  1  serial line, idle high.
- busy_o  output  1  frame in progress.
- done_o  output  1  one-cycle pulse at frame completion.

Interface rule: one clock; reset is synchronous and active-high (clk_i, rst_i).

Behaviour:
- Reset values (rst_i sampled high at a posedge): tx_o=1, ready_o=0, busy_o=0, done_o=0, FSM=IDLE, all counters 0.
- All outputs are registered.
- Handshake: a byte is accepted on a posedge where valid_i && ready_o.
- ready_o = (state==IDLE) && cfg_en_i && !rst_i.
- While valid_i is high and ready_o is low, the source holds data_i stable. No internal FIFO.
- On accept, the block latches data_i, cfg_div_i, cfg_parity_en_i and cfg_stop_bits_i. Changes to cfg_* mid-frame have no effect on that frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on accept; tx_o goes 0 on the following edge, i.e. 1 cycle of latency from accept.
  - START -> DATA after div+1 cycles.
  - DATA shifts out bit[0] first. Each bit is held div+1 cycles. A 3-bit counter advances; after bit 7 the FSM goes to PARITY if parity is enabled, else to STOP.
  - PARITY drives ^data for div+1 cycles, then goes to STOP.
  - STOP holds tx_o=1 for (div+1) or 2*(div+1) cycles, then returns to IDLE.
- Baud counter: counts 0..div and wraps to 0 at each bit boundary.
- div=0 is legal: one cycle per bit.
- div = all-ones is legal: no overflow, because the counter has DIV_WIDTH bits and compares for equality.
- Frame length in cycles = (10 + P + S - 1) * (div+1), where P = parity enabled (0/1) and S = number of stop bits (1/2).
- done_o: pulses 1 for exactly one cycle, the first IDLE cycle after STOP completes.
- busy_o: 1 from the cycle after accept through the last STOP cycle.
- Back-to-back frames: ready_o rises in the same cycle as done_o. If valid_i is high, the next start bit begins one cycle later. This gives exactly 1 extra idle-high cycle between frames.
- cfg_en_i deasserted mid-frame: the current frame completes normally; no further accepts.
- rst_i mid-frame: the frame is aborted, tx_o returns to 1 on that edge, and done_o is not pulsed.
- Simultaneous rst_i and valid_i: reset wins; the byte is not accepted.

Test Plan:
- Single byte 0xA5, div=3, parity on, 1 stop: tx_o = 0 | 1,0,1,0,0,1,0,1 | parity 0 | 1, each bit 4 cycles, 44 cycles total; done_o pulses once, 45 cycles after accept.
- Byte 0x07, div=0, parity on, 2 stop: bits 0|1,1,1,0,0,0,0,0|1|1,1, 12 cycles; parity bit = 1.
- Back-to-back 0x55 then 0x0A with valid_i held high, div=1, parity off, 1 stop: second start bit falls exactly 21 cycles after the first start bit (20 frame cycles + 1 idle).
- rst_i asserted during data bit 3 of 0xFF: tx_o = 1 on that edge, no done_o, ready_o = 0 during reset. After release with cfg_en_i=1, ready_o returns to 1 and a new byte transmits correctly.
- cfg_div_i changed from 3 to 7, and cfg_en_i dropped, mid-frame: the current frame keeps 4-cycle bits and completes; ready_o stays 0 afterwards.
- End-to-end: drive the string "Hello\n" through the block into the RX monitor at matching baud. The monitor prints "Hello" and reports no parity errors.
